// File: rtl/muldiv_seq.sv
// Iterative RV32M multiply/divide sequencer: 32-step shift-add multiply and restoring divide.
// Define MULDIV_EARLY_OUT_EN to bypass iteration for divide-by-zero, signed overflow and zero multiplies.
module muldiv_seq #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 5
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic            kill,
    input  logic [2:0]      funct,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            busy,
    output logic            stall,
    output logic            valid,
    output logic [XLEN-1:0] result
);
    typedef enum logic [1:0] {S_IDLE, S_ITER, S_FIX, S_DONE} state_t;

    localparam logic [2:0]      F_MUL    = 3'b000;
    localparam logic [2:0]      F_MULH   = 3'b001;
    localparam logic [2:0]      F_MULHSU = 3'b010;
    localparam logic [2:0]      F_DIV    = 3'b100;
    localparam logic [2:0]      F_REM    = 3'b110;
    localparam logic [XLEN-1:0] SMIN     = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [XLEN-1:0] ONES     = {XLEN{1'b1}};

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       fn;
    logic             a_neg, b_neg, div0, ovf;
    logic [XLEN-1:0]  a_raw, opnd, acc, lo;

    function automatic logic a_is_signed(input logic [2:0] f);
        return (f == F_MULH) || (f == F_MULHSU) || (f == F_DIV) || (f == F_REM);
    endfunction

    function automatic logic b_is_signed(input logic [2:0] f);
        return (f == F_MULH) || (f == F_DIV) || (f == F_REM);
    endfunction

    function automatic logic [XLEN-1:0] neg_if(input logic [XLEN-1:0] v, input logic n);
        return n ? -v : v;
    endfunction

    function automatic logic [2*XLEN-1:0] neg_if_w(input logic [2*XLEN-1:0] v, input logic n);
        return n ? -v : v;
    endfunction

    logic signed [XLEN-1:0] a_s, b_s;
    logic                   accept, is_div_in, a_neg_in, b_neg_in, div0_in, ovf_in, early_in;
    logic [XLEN-1:0]        a_abs, b_abs;

    assign a_s       = a;
    assign b_s       = b;
    assign is_div_in = funct[2];
    assign a_neg_in  = a_is_signed(funct) && (a_s < 0);
    assign b_neg_in  = b_is_signed(funct) && (b_s < 0);
    assign a_abs     = neg_if(a, a_neg_in);
    assign b_abs     = neg_if(b, b_neg_in);
    assign div0_in   = is_div_in && (b == '0);
    assign ovf_in    = ((funct == F_DIV) || (funct == F_REM)) && (a == SMIN) && (b == ONES);

`ifdef MULDIV_EARLY_OUT_EN
    assign early_in = div0_in || ovf_in || (!is_div_in && ((a == '0) || (b == '0)));
`else
    assign early_in = 1'b0;
`endif

    assign accept = start && !kill && ((state == S_IDLE) || (state == S_DONE));
    assign stall  = busy || accept;

    // Per-iteration datapath: {acc, lo} is the product register for multiply,
    // and acc/lo are remainder/quotient-shift for divide.
    logic [XLEN:0]   mul_sum, rem_sh;
    logic [XLEN-1:0] rem_sub;
    logic            rem_ge;

    assign mul_sum = {1'b0, acc} + (lo[0] ? {1'b0, opnd} : {(XLEN+1){1'b0}});
    assign rem_sh  = {acc, lo[XLEN-1]};
    assign rem_ge  = rem_sh >= {1'b0, opnd};
    assign rem_sub = rem_sh[XLEN-1:0] - opnd;

    // Sign correction and special-case override
    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   fix_res;

    always_comb begin
        prod_fix = neg_if_w({acc, lo}, a_neg ^ b_neg);
        fix_res  = '0;
        if (!fn[2])
            fix_res = (fn == F_MUL) ? prod_fix[XLEN-1:0] : prod_fix[2*XLEN-1:XLEN];
        else if (div0)
            fix_res = fn[1] ? a_raw : ONES;
        else if (ovf)
            fix_res = fn[1] ? '0 : SMIN;
        else if (fn[1])
            fix_res = neg_if(acc, a_neg);
        else
            fix_res = neg_if(lo, a_neg ^ b_neg);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= S_IDLE;
            busy   <= 1'b0;
            valid  <= 1'b0;
            result <= '0;
            cnt    <= '0;
            fn     <= '0;
            a_neg  <= 1'b0;
            b_neg  <= 1'b0;
            div0   <= 1'b0;
            ovf    <= 1'b0;
            a_raw  <= '0;
            opnd   <= '0;
            acc    <= '0;
            lo     <= '0;
        end else begin
            valid <= 1'b0;
            if (accept) begin
                state <= early_in ? S_FIX : S_ITER;
                busy  <= 1'b1;
                cnt   <= '0;
                fn    <= funct;
                a_neg <= a_neg_in;
                b_neg <= b_neg_in;
                div0  <= div0_in;
                ovf   <= ovf_in;
                a_raw <= a;
                acc   <= '0;
                opnd  <= is_div_in ? b_abs : a_abs;
                lo    <= is_div_in ? a_abs : (early_in ? '0 : b_abs);
            end else begin
                case (state)
                    S_ITER: begin
                        if (kill) begin
                            state <= S_IDLE;
                            busy  <= 1'b0;
                        end else begin
                            if (fn[2]) begin
                                acc <= rem_ge ? rem_sub : rem_sh[XLEN-1:0];
                                lo  <= {lo[XLEN-2:0], rem_ge};
                            end else begin
                                acc <= mul_sum[XLEN:1];
                                lo  <= {mul_sum[0], lo[XLEN-1:1]};
                            end
                            cnt <= cnt + 1'b1;
                            if (cnt == CNT_W'(XLEN-1))
                                state <= S_FIX;
                        end
                    end
                    S_FIX: begin
                        busy <= 1'b0;
                        if (kill) begin
                            state <= S_IDLE;
                        end else begin
                            result <= fix_res;
                            valid  <= 1'b1;
                            state  <= S_DONE;
                        end
                    end
                    default: begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_muldiv_seq.sv
// Self-checking bench for muldiv_seq: cycle-level reference model plus directed vectors.
module tb_muldiv_seq;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        kill = 1'b0;
    logic [2:0]  funct = 3'b000;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        busy, stall, valid;
    logic [31:0] result;

`ifdef MULDIV_EARLY_OUT_EN
    localparam int LAT_EARLY = 2;
`else
    localparam int LAT_EARLY = 34;
`endif

    muldiv_seq #(.XLEN(32), .CNT_W(5)) dut (
        .clk(clk), .reset(reset), .start(start), .kill(kill), .funct(funct),
        .a(a), .b(b), .busy(busy), .stall(stall), .valid(valid), .result(result)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %08h expected %08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // RV32M result rules computed with plain integer arithmetic
    function automatic logic [31:0] mdl(input logic [2:0] f, input logic [31:0] x, input logic [31:0] y);
        longint     sx, sy, ux, uy;
        logic [63:0] p;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        ux = longint'({32'b0, x});
        uy = longint'({32'b0, y});
        case (f)
            3'd0: begin p = sx * sy; return p[31:0]; end
            3'd1: begin p = sx * sy; return p[63:32]; end
            3'd2: begin p = sx * uy; return p[63:32]; end
            3'd3: begin p = ux * uy; return p[63:32]; end
            3'd4: begin
                if (y == 32'd0) return 32'hFFFF_FFFF;
                if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 32'h8000_0000;
                return 32'(sx / sy);
            end
            3'd5: return (y == 32'd0) ? 32'hFFFF_FFFF : x / y;
            3'd6: begin
                if (y == 32'd0) return x;
                if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 32'd0;
                return 32'(sx % sy);
            end
            default: return (y == 32'd0) ? x : x % y;
        endcase
    endfunction

    function automatic int lat_of(input logic [2:0] f, input logic [31:0] x, input logic [31:0] y);
`ifdef MULDIV_EARLY_OUT_EN
        if (f[2] && y == 32'd0) return 2;
        if ((f == 3'd4 || f == 3'd6) && x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 2;
        if (!f[2] && (x == 32'd0 || y == 32'd0)) return 2;
`endif
        return 34;
    endfunction

    // Reference model: one pending operation with its accept and completion cycles
    bit          pend = 1'b0;
    int          t_acc = 0;
    int          t_done = 0;
    logic [31:0] pend_res = '0;
    logic [31:0] held = '0;

    always @(negedge clk) begin
        bit          eb, ev, acc;
        logic [31:0] er;
        if (chk_en) begin
            eb  = pend && (cyc > t_acc) && (cyc < t_done);
            ev  = pend && (cyc == t_done);
            er  = ev ? pend_res : held;
            acc = start && !kill && !eb;
            check("busy", {31'b0, busy}, {31'b0, eb});
            check("valid", {31'b0, valid}, {31'b0, ev});
            check("stall", {31'b0, stall}, {31'b0, eb || acc});
            check("result", result, er);
            if (reset) begin
                pend = 1'b0;
                held = '0;
            end else begin
                if (ev) begin
                    held = pend_res;
                    pend = 1'b0;
                end
                if (eb && kill) pend = 1'b0;
                if (acc) begin
                    pend     = 1'b1;
                    t_acc    = cyc;
                    t_done   = cyc + lat_of(funct, a, b);
                    pend_res = mdl(funct, a, b);
                end
            end
        end
    end

    task automatic issue(input logic [2:0] f, input logic [31:0] x, input logic [31:0] y, output int t);
        @(posedge clk); #1;
        start = 1'b1; funct = f; a = x; b = y;
        t = cyc;
        @(posedge clk); #1;
        start = 1'b0; a = $urandom; b = $urandom; funct = 3'($urandom_range(0, 7));
    endtask

    task automatic step_to(input int target);
        for (int i = 0; i < 200 && cyc != target; i++) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic wait_valid(output int vc, output logic [31:0] r, output bit ok);
        ok = 1'b0; vc = 0; r = '0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (valid) begin
                vc = cyc; r = result; ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic run_op(input string nm, input logic [2:0] f, input logic [31:0] x,
                          input logic [31:0] y, input logic [31:0] ex, input bit early);
        int t, vc; logic [31:0] r; bit ok;
        issue(f, x, y, t);
        wait_valid(vc, r, ok);
        check({nm, "_seen"}, {31'b0, ok}, 32'd1);
        if (ok) begin
            check(nm, r, ex);
            check({nm, "_lat"}, 32'(vc - t), 32'(early ? LAT_EARLY : 34));
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got no finish, expected finish before time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0, vc, nv; logic [31:0] r; bit ok;

        check("mdl_mul",    mdl(3'd0, 32'd7, 32'hFFFF_FFFD), 32'hFFFF_FFEB);
        check("mdl_mulhu",  mdl(3'd3, 32'd7, 32'hFFFF_FFFD), 32'h0000_0006);
        check("mdl_rem",    mdl(3'd6, 32'hFFFF_FFEC, 32'd3), 32'hFFFF_FFFE);
        check("mdl_divovf", mdl(3'd4, 32'h8000_0000, 32'hFFFF_FFFF), 32'h8000_0000);

        @(posedge clk); @(posedge clk); #1;
        chk_en = 1'b1;
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_valid", {31'b0, valid}, 32'd0);
        check("rst_result", result, 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;

        run_op("mul",      3'd0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b0);
        run_op("mulh",     3'd1, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0);
        run_op("mulhu",    3'd3, 32'd7,          32'hFFFF_FFFD, 32'h0000_0006, 1'b0);
        run_op("mulh_min", 3'd1, 32'h8000_0000,  32'h8000_0000, 32'h4000_0000, 1'b0);
        run_op("div",      3'd4, 32'hFFFF_FFEC,  32'd3,         32'hFFFF_FFFA, 1'b0);
        run_op("rem",      3'd6, 32'hFFFF_FFEC,  32'd3,         32'hFFFF_FFFE, 1'b0);
        run_op("divu",     3'd5, 32'hFFFF_FFFF,  32'd2,         32'h7FFF_FFFF, 1'b0);
        run_op("div_neg",  3'd4, 32'd7,          32'hFFFF_FFFE, 32'hFFFF_FFFD, 1'b0);
        run_op("rem_negb", 3'd6, 32'd20,         32'hFFFF_FFFD, 32'h0000_0002, 1'b0);
        run_op("divu_z",   3'd5, 32'd5,          32'd0,         32'hFFFF_FFFF, 1'b1);
        run_op("rem_z",    3'd6, 32'd5,          32'd0,         32'h0000_0005, 1'b1);
        run_op("remu_z",   3'd7, 32'd5,          32'd0,         32'h0000_0005, 1'b1);
        run_op("div_z",    3'd4, 32'hFFFF_FFFF,  32'd0,         32'hFFFF_FFFF, 1'b1);
        run_op("div_ovf",  3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1'b1);
        run_op("rem_ovf",  3'd6, 32'h8000_0000,  32'hFFFF_FFFF, 32'h0000_0000, 1'b1);
        run_op("mul_zero", 3'd0, 32'd0,          32'd12345,     32'h0000_0000, 1'b1);

        // Back-to-back: second start lands in the DONE cycle; a mid-ITER start is ignored
        issue(3'd0, 32'd7, 32'hFFFF_FFFD, t0);
        step_to(t0 + 5);
        start = 1'b1; funct = 3'd5; a = 32'd1; b = 32'd1;
        step_to(t0 + 6);
        start = 1'b0;
        step_to(t0 + 34);
        check("b2b_first_valid", {31'b0, valid}, 32'd1);
        check("b2b_first_res", result, 32'hFFFF_FFEB);
        start = 1'b1; funct = 3'd4; a = 32'hFFFF_FFEC; b = 32'd3;
        step_to(t0 + 35);
        start = 1'b0;
        wait_valid(vc, r, ok);
        check("b2b_second_seen", {31'b0, ok}, 32'd1);
        check("b2b_gap", 32'(vc - t0), 32'd68);
        check("b2b_second_res", r, 32'hFFFF_FFFA);

        // kill mid-divide: no valid, result retained
        issue(3'd4, 32'd100, 32'd7, t0);
        step_to(t0 + 10);
        kill = 1'b1;
        step_to(t0 + 11);
        kill = 1'b0;
        check("kill_busy", {31'b0, busy}, 32'd0);
        nv = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (valid) nv++;
        end
        check("kill_no_valid", 32'(nv), 32'd0);
        check("kill_held", result, 32'hFFFF_FFFA);

        // start together with kill is not accepted
        @(posedge clk); #1;
        start = 1'b1; kill = 1'b1; funct = 3'd0; a = 32'd3; b = 32'd3;
        @(posedge clk); #1;
        start = 1'b0; kill = 1'b0;
        check("startkill_busy", {31'b0, busy}, 32'd0);
        run_op("after_kill", 3'd4, 32'd100, 32'd7, 32'd14, 1'b0);

        // reset mid-MULHSU
        issue(3'd2, 32'd7, 32'hFFFF_FFFD, t0);
        step_to(t0 + 15);
        reset = 1'b1;
        step_to(t0 + 16);
        reset = 1'b0;
        check("rstmid_busy", {31'b0, busy}, 32'd0);
        check("rstmid_valid", {31'b0, valid}, 32'd0);
        check("rstmid_result", result, 32'd0);
        run_op("mulhsu", 3'd2, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF, 1'b0);

        repeat (3) @(posedge clk);
        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/muldiv_seq.md
Name: muldiv_seq

Overview:
- Iterative RV32M multiply/divide sequencer that sits beside the execute-stage ALU.
- Accepts one M-extension operation at a time, runs a 32-step shift-add multiply or restoring divide, and produces a 32-bit result.
- Drives a stall request so the pipeline controller holds the execute stage until the result is valid.
- The base ALU decoder still handles all non-M operations; this block handles only funct7=0000001 with opcode OPC_ARI_RTYPE.

Parameters:
- XLEN, 32, operand/result width; only 32 is supported.
- CNT_W, 5, iteration counter width (log2 XLEN).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request pulse; sampled only in IDLE or DONE.
- kill  input  1  pipeline flush; aborts the operation in flight.
- funct  input  3  M-ext funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- a  input  XLEN  rs1 operand.
- b  input  XLEN  rs2 operand.
- busy  output  1  high while iterating.
- stall  output  1  equals busy OR (start AND accepted); combinational.
- valid  output  1  one-cycle pulse when result is final.
- result  output  XLEN  final result; held until the next accepted start.

Behaviour:
- Reset: state=IDLE, busy=0, valid=0, result=0, counter=0, all internal registers 0.
- States:
  - IDLE: start accepted -> LOAD-into-ITER.
  - ITER: counter==31 completes -> FIX; otherwise stays in ITER.
  - FIX: always -> DONE.
  - DONE: start accepted -> ITER; otherwise -> IDLE.
- Acceptance: start is accepted when state is IDLE or DONE and kill=0. On acceptance, latch funct, capture absolute values of a/b per signedness, record sign flags, clear the counter, and enter ITER.
- Signedness:
  - a is signed for MULH, MULHSU, DIV, REM.
  - b is signed for MULH, DIV, REM.
  - MUL uses the low 32 bits, so signedness is irrelevant.
- ITER, multiply: 64-bit product register; each cycle add the shifted multiplicand if the multiplier LSB is 1, then shift; 32 cycles.
- ITER, divide: restoring divide, one quotient bit per cycle, MSB first; remainder register is 33 bits wide.
- FIX:
  - Apply sign correction: two's-complement negate the product if the operand signs differ; quotient negated if signs differ; remainder takes the sign of the dividend.
  - Select the result: low 32 bits for MUL, high 32 bits for MULH/MULHSU/MULHU.
- Special cases, enforced in FIX regardless of the iterated value:
  - Divide by zero: DIV/DIVU result 0xFFFFFFFF; REM/REMU result = a.
  - Signed overflow (a=0x80000000, b=0xFFFFFFFF): DIV result 0x80000000; REM result 0.
- DONE: valid=1 for exactly this cycle; result is registered on entry to DONE.
- Latency: start accepted in cycle 0 -> busy high cycles 1..33 (ITER x32, FIX x1) -> valid in cycle 34.
- stall is high from the accept cycle through cycle 33; it is low in the DONE cycle so the pipeline advances with the result.
- Back-to-back operation: start in the DONE cycle is accepted; valid still pulses in that cycle and the new op begins.
- start while busy: ignored, no queuing.
- kill:
  - In ITER or FIX: go to IDLE next cycle, no valid pulse, result unchanged.
  - Same cycle as start: the start is not accepted.
  - In DONE: valid still pulses.
- reset: overrides everything on the next edge, including mid-iteration; valid=0 and result=0 afterwards.
- Operand inputs are not required stable after the accept cycle.

Optional Feature:
- Macro: MULDIV_EARLY_OUT_EN.
- When defined:
  - Divide-by-zero, signed overflow, and multiply with either operand zero skip ITER: accept (cycle 0) -> FIX (cycle 1) -> DONE with valid (cycle 2).
  - stall is high only in cycles 0-1.
- When undefined: every operation takes the full 34-cycle latency; special-case values come from the FIX override.

Test Plan:
- MUL a=7, b=-3 (0xFFFFFFFD) -> valid at cycle 34, result 0xFFFFFFEB; MULH of the same operands -> 0xFFFFFFFF; MULHU -> 0x00000006.
- DIV a=-20, b=3 -> 0xFFFFFFFA; REM a=-20, b=3 -> 0xFFFFFFFE; DIVU 0xFFFFFFFF/2 -> 0x7FFFFFFF.
- DIVU a=5, b=0 -> 0xFFFFFFFF; REM a=5, b=0 -> 5; DIV 0x80000000/0xFFFFFFFF -> 0x80000000 with REM 0. With MULDIV_EARLY_OUT_EN these give valid at cycle 2, otherwise at cycle 34.
- Back-to-back: start MUL, then start DIV in the DONE cycle -> two valid pulses exactly 34 cycles apart; start pulses issued mid-ITER are ignored.
- kill at cycle 10 of a DIV -> busy low at cycle 11, no valid pulse, result retains the previous value; a subsequent start behaves normally.
- reset asserted at cycle 15 of a MULHSU -> next cycle busy=0, valid=0, result=0, state IDLE.
